// File: rtl/me_row_realign.sv
// Byte-granular row realigner: shifts a row of DATA_W-bit words left by cfg_shift_i bytes.
// Define ME_EDGE_REPLICATE_EN to pad the final word with the last pixel instead of zeros.
module me_row_realign #(
  parameter int DATA_W = 128,
  parameter int SH_W   = 4,
  parameter int LEN_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic [SH_W-1:0]   cfg_shift_i,
  input  logic [LEN_W-1:0]  cfg_words_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_last_o,
  output logic              busy_o,
  output logic              done_o
);
  localparam int NB = DATA_W / 8;

  typedef enum logic [2:0] {IDLE, PRIME, STREAM, FLUSH, DRAIN} state_t;

  state_t              r_state;
  logic [SH_W-1:0]     r_shift;
  logic [LEN_W-1:0]    r_len;
  logic [LEN_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_hold;
  logic [DATA_W-1:0]   r_out_data;
  logic                r_out_valid;
  logic                r_out_last;
  logic                r_done;

  logic                w_slot_free;
  logic                w_in_ready;
  logic                w_accept;
  logic [DATA_W-1:0]   w_pad;

  assign w_slot_free = !r_out_valid || out_ready_i;
  assign w_accept    = in_valid_i && w_in_ready;

  always_comb begin
    w_in_ready = 1'b0;
    case (r_state)
      PRIME:   w_in_ready = 1'b1;
      STREAM:  w_in_ready = w_slot_free;
      default: w_in_ready = 1'b0;
    endcase
  end

`ifdef ME_EDGE_REPLICATE_EN
  assign w_pad = {NB{r_hold[DATA_W-1 -: 8]}};
`else
  assign w_pad = '0;
`endif

  // Low word of {next,hold} after dropping s bytes: bytes s.. of the two-word stream.
  function automatic logic [DATA_W-1:0] combine(input logic [DATA_W-1:0] h,
                                                input logic [DATA_W-1:0] n,
                                                input logic [SH_W-1:0]   s);
    logic [2*DATA_W-1:0] t;
    t = {n, h} >> {s, 3'b000};
    return t[DATA_W-1:0];
  endfunction

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state     <= IDLE;
      r_shift     <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_hold      <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start_i) begin
            if (cfg_words_i != '0) begin
              r_shift <= cfg_shift_i;
              r_len   <= cfg_words_i;
              r_cnt   <= '0;
              r_state <= PRIME;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        PRIME: begin
          if (w_accept) begin
            r_hold  <= in_data_i;
            r_cnt   <= LEN_W'(1);
            r_state <= (r_len == LEN_W'(1)) ? FLUSH : STREAM;
          end
        end
        STREAM: begin
          // r_cnt is the index of the word being accepted; it never exceeds len-1 here.
          if (w_accept) begin
            r_out_data  <= combine(r_hold, in_data_i, r_shift);
            r_out_valid <= 1'b1;
            r_out_last  <= 1'b0;
            r_hold      <= in_data_i;
            r_cnt       <= r_cnt + LEN_W'(1);
            if (r_cnt == r_len - LEN_W'(1)) r_state <= FLUSH;
          end else if (r_out_valid && out_ready_i) begin
            r_out_valid <= 1'b0;
          end
        end
        FLUSH: begin
          if (w_slot_free) begin
            r_out_data  <= combine(r_hold, w_pad, r_shift);
            r_out_valid <= 1'b1;
            r_out_last  <= 1'b1;
            r_state     <= DRAIN;
          end
        end
        DRAIN: begin
          if (r_out_valid && out_ready_i) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_done      <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready_o  = w_in_ready;
  assign out_valid_o = r_out_valid;
  assign out_data_o  = r_out_data;
  assign out_last_o  = r_out_last;
  assign busy_o      = (r_state != IDLE);
  assign done_o      = r_done;

endmodule

// File: tb/tb_me_row_realign.sv
// Self-checking bench for me_row_realign: byte-level reference model feeding a scoreboard queue.
module tb_me_row_realign;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [3:0]   cfg_shift;
  logic [7:0]   cfg_words;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         out_last;
  logic         busy;
  logic         done;

  me_row_realign #(.DATA_W(128), .SH_W(4), .LEN_W(8)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .cfg_shift_i(cfg_shift),
    .cfg_words_i(cfg_words), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_data_i(in_data), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_data_o(out_data), .out_last_o(out_last), .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [127:0] d;
    logic         l;
  } exp_t;

  exp_t         q[$];
  logic [127:0] rw [0:255];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rdy_mode = 0;
  int done_seen = 0;
  int done_cyc = 0;
  bit mon_en = 1'b1;
  bit pend = 1'b0;
  logic [127:0] pend_d;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: stream bytes of H then N, output byte i = stream byte i+s.
  function automatic logic [127:0] ref_comb(input logic [127:0] h, input logic [127:0] n, input int s);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      if (i + s < 16) r[8*i +: 8] = h[8*(i+s) +: 8];
      else            r[8*i +: 8] = n[8*(i+s-16) +: 8];
    end
    return r;
  endfunction

  function automatic logic [127:0] ref_pad(input logic [127:0] last_word);
`ifdef ME_EDGE_REPLICATE_EN
    return {16{last_word[127:120]}};
`else
    return (last_word & 128'h0);
`endif
  endfunction

  always @(negedge clk) begin
    if (!rst_n || !mon_en) begin
      pend = 1'b0;
    end else begin
      if (done) begin
        done_seen++;
        done_cyc = cyc;
      end
      if (pend) begin
        chk("hold_valid", {127'd0, out_valid}, 128'd1);
        chk("hold_data", out_data, pend_d);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("extra_output", 128'd1, 128'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("out_data", out_data, e.d);
          chk("out_last", {127'd0, out_last}, {127'd0, e.l});
        end
      end
      pend   = out_valid && !out_ready;
      pend_d = out_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ~out_ready;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic fill_rand(input int len);
    for (int i = 0; i < len; i++) rw[i] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic run_row(input int s, input int len, input int mode, input int ivr, input int exp_lat);
    int d0, idx, guard, start_cyc;
    bit acc;
    rdy_mode = mode;
    for (int k = 0; k < len; k++) begin
      exp_t e;
      e.d = ref_comb(rw[k], (k < len - 1) ? rw[k+1] : ref_pad(rw[len-1]), s);
      e.l = (k == len - 1);
      q.push_back(e);
    end
    d0 = done_seen;
    start = 1'b1; cfg_shift = 4'(s); cfg_words = 8'(len);
    tick();
    start_cyc = cyc;
    start = 1'b0;
    idx = 0; guard = 0;
    while (idx < len && guard < 5000) begin
      in_valid  = ivr ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_data   = rw[idx];
      start     = ($urandom_range(0, 3) == 0);
      cfg_shift = 4'($urandom);
      cfg_words = 8'($urandom);
      @(negedge clk);
      acc = in_valid && in_ready;
      tick();
      if (acc) idx++;
      guard++;
    end
    in_valid = 1'b0; start = 1'b0; in_data = '0;
    chk("inputs_accepted", 128'(idx), 128'(len));
    guard = 0;
    while (done_seen == d0 && guard < 5000) begin
      tick();
      guard++;
    end
    if (exp_lat >= 0) chk("row_latency", 128'(done_cyc - start_cyc), 128'(exp_lat));
    repeat (3) tick();
    chk("done_pulses", 128'(done_seen - d0), 128'd1);
    chk("queue_empty", 128'(q.size()), 128'd0);
    chk("busy_idle", {127'd0, busy}, 128'd0);
  endtask

  initial begin
    int d0;
    rst_n = 1'b0; start = 1'b0; cfg_shift = '0; cfg_words = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("rst_out_data", out_data, 128'd0);
    chk("rst_flags", {124'd0, out_last, busy, done, in_ready}, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // T1: s=1, len=2, bytes 00..1F
    for (int i = 0; i < 16; i++) begin
      rw[0][8*i +: 8] = 8'(i);
      rw[1][8*i +: 8] = 8'(16 + i);
    end
    run_row(1, 2, 0, 0, 4);
    run_row(1, 2, 1, 1, -1);

    // T2: s=0 passthrough, full rate
    fill_rand(3);
    run_row(0, 3, 0, 0, 5);

    // T3: s=15, len=4, full rate
    fill_rand(4);
    run_row(15, 4, 0, 0, 6);

    // T4: backpressure
    fill_rand(20);
    run_row(7, 20, 1, 1, -1);
    fill_rand(12);
    run_row(3, 12, 2, 1, -1);

    // T5: zero-length row, then single-word row
    d0 = done_seen;
    start = 1'b1; cfg_words = 8'd0; cfg_shift = 4'd2;
    tick();
    start = 1'b0;
    chk("zero_len_done", {127'd0, done}, 128'd1);
    chk("zero_len_busy", {127'd0, busy}, 128'd0);
    tick();
    chk("zero_len_done_clr", {127'd0, done}, 128'd0);
    chk("zero_len_busy2", {127'd0, busy}, 128'd0);
    chk("zero_len_pulses", 128'(done_seen - d0), 128'd1);
    fill_rand(1);
    run_row(5, 1, 0, 0, 3);

    // T6: reset mid-row after 2 of 5 words
    mon_en = 1'b0;
    rdy_mode = 0;
    fill_rand(5);
    d0 = done_seen;
    start = 1'b1; cfg_shift = 4'd4; cfg_words = 8'd5;
    tick();
    start = 1'b0; in_valid = 1'b1; in_data = rw[0];
    tick();
    in_data = rw[1];
    tick();
    in_valid = 1'b0;
    chk("pre_rst_valid", {127'd0, out_valid}, 128'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_valid", {127'd0, out_valid}, 128'd0);
    chk("abort_data", out_data, 128'd0);
    chk("abort_flags", {124'd0, out_last, busy, done, in_ready}, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
    tick();
    chk("abort_no_done", 128'(done_seen - d0), 128'd0);
    fill_rand(5);
    run_row(9, 5, 0, 0, 7);

    // Maximum row length, random handshakes
    fill_rand(255);
    run_row(9, 255, 2, 1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
